// File: rtl/alu_sweep_driver.sv
// Sweep engine for the 8-bit CLA ALU: drives F=0..7 with one operand pair,
// holds each code for HOLD cycles and captures {w, g, CarryOut} per code.
module alu_sweep_driver #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 150
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_g,
    input  logic             alu_co,
    input  logic             rd_en,
    input  logic [2:0]       rd_idx,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_w,
    output logic             rd_g,
    output logic             rd_co
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] RELOAD = 16'(HOLD - 1);

    state_t           state;
    state_t           nextState;
    logic [15:0]      holdCnt;
    logic             capture;
    logic             lastCode;
    logic             accept;
    logic [WIDTH+1:0] resultBuf [8];

    assign accept   = (state == IDLE) && start;
    assign capture  = (state == RUN) && (holdCnt == 16'd0);
    assign lastCode = (alu_f == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start) nextState = RUN;
            RUN:  if (capture && lastCode) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Operands and code only move on start or code advance, so the ALU
    // sees stable inputs for the whole hold window before each capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_f   <= 3'd0;
            holdCnt <= 16'd0;
            done    <= 1'b0;
        end else begin
            done <= capture && lastCode;
            if (accept) begin
                alu_a   <= a_in;
                alu_b   <= b_in;
                alu_f   <= 3'd0;
                holdCnt <= RELOAD;
            end else if (capture) begin
                if (!lastCode) begin
                    alu_f   <= alu_f + 3'd1;
                    holdCnt <= RELOAD;
                end
            end else if (state == RUN) begin
                holdCnt <= holdCnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                resultBuf[i] <= '0;
            end
        end else if (capture) begin
            resultBuf[alu_f] <= {alu_w, alu_g, alu_co};
        end
    end

    // Registered read: a same-edge capture is not visible until next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_w     <= '0;
            rd_g     <= 1'b0;
            rd_co    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                {rd_w, rd_g, rd_co} <= resultBuf[rd_idx];
            end
        end
    end

endmodule
